wb_semaphore_client: RTL

//  Wishbone master that acquires and releases one lock in a wb_semaphore slave on behalf of a local requester.

---
 rtl/wb_semaphore_client_if.sv | 28 ++
 rtl/wb_semaphore_client.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_semaphore_client_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_semaphore_client_if
// Description : Wishbone bus bundle between a semaphore client and the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_semaphore_client_if #(
  parameter int DBUS_WIDTH = 32
);
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [2:0]            wb_adr_o;
  logic [DBUS_WIDTH-1:0] wb_dat_o;
  logic [DBUS_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/wb_semaphore_client.sv
`default_nettype none
// ============================================================================
// Module      : wb_semaphore_client
// Description : Wishbone master acquiring/releasing one semaphore lock with
//               fixed-backoff polling, retry budget and ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_semaphore_client #(
  parameter int DBUS_WIDTH = 32,
  parameter int BACKOFF    = 16,
  parameter int MAX_TRIES  = 0,
  parameter int ACK_TMO    = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 acq_req_i,
  input  logic [2:0]           sem_sel_i,
  output logic                 acq_grant_o,
  output logic                 busy_o,
  output logic                 fail_o,
  wb_semaphore_client_if.master bus
);

  localparam int c_bo_w  = $clog2(BACKOFF + 1);
  localparam int c_tmo_w = $clog2(ACK_TMO + 1);
  localparam logic [c_bo_w-1:0]  c_bo_last  = c_bo_w'(BACKOFF - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(ACK_TMO - 1);
  localparam logic [15:0]        c_max_tries = 16'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POLL = 3'd1,
    S_WAIT = 3'd2,
    S_HELD = 3'd3,
    S_REL  = 3'd4,
    S_FAIL = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_cyc;
  logic                r_we;
  logic [2:0]          r_adr;
  logic                r_grant;
  logic                r_busy;
  logic                r_fail;
  logic [15:0]         r_tries;
  logic [c_bo_w-1:0]   r_bo;
  logic [c_tmo_w-1:0]  r_tmo;

  logic [15:0]         w_tries_inc;
  logic                w_exhausted;

  assign w_tries_inc = (r_tries == 16'hFFFF) ? r_tries : r_tries + 16'd1;
  assign w_exhausted = (MAX_TRIES != 0) && (w_tries_inc == c_max_tries);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state <= S_IDLE;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= 3'd0;
      r_grant <= 1'b0;
      r_busy  <= 1'b0;
      r_fail  <= 1'b0;
      r_tries <= 16'd0;
      r_bo    <= '0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (acq_req_i) begin
            r_adr   <= sem_sel_i;
            r_tries <= 16'd0;
            r_tmo   <= '0;
            r_cyc   <= 1'b1;
            r_we    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_POLL;
          end
        end
        S_POLL: begin
          if (bus.wb_ack_i) begin
            r_cyc <= 1'b0;
            if (!bus.wb_dat_i[0]) begin
              if (acq_req_i) begin
                r_grant <= 1'b1;
                r_state <= S_HELD;
              end else begin
                // Lock won but no longer wanted: hand it straight back.
                r_tmo   <= '0;
                r_state <= S_REL;
              end
            end else begin
              r_tries <= w_tries_inc;
              if (w_exhausted) begin
                r_fail  <= 1'b1;
                r_state <= S_FAIL;
              end else if (!acq_req_i) begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_bo    <= '0;
                r_state <= S_WAIT;
              end
            end
          end else if (r_tmo == c_tmo_last) begin
            r_cyc   <= 1'b0;
            r_fail  <= 1'b1;
            r_state <= S_FAIL;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_WAIT: begin
          if (!acq_req_i) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_bo == c_bo_last) begin
            r_tmo   <= '0;
            r_cyc   <= 1'b1;
            r_state <= S_POLL;
          end else begin
            r_bo <= r_bo + 1'b1;
          end
        end
        S_HELD: begin
          if (!acq_req_i) begin
            r_grant <= 1'b0;
            r_tmo   <= '0;
            r_cyc   <= 1'b1;
            r_we    <= 1'b1;
            r_state <= S_REL;
          end
        end
        S_REL: begin
          // Entered straight from a poll ack the bus is still idle; launch here.
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_we  <= 1'b1;
          end else if (bus.wb_ack_i) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_tmo == c_tmo_last) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_fail  <= 1'b1;
            r_state <= S_FAIL;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_FAIL: begin
          r_fail  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_cyc   <= 1'b0;
          r_we    <= 1'b0;
          r_grant <= 1'b0;
          r_busy  <= 1'b0;
          r_fail  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign acq_grant_o  = r_grant;
  assign busy_o       = r_busy;
  assign fail_o       = r_fail;
  assign bus.wb_cyc_o = r_cyc;
  assign bus.wb_stb_o = r_cyc;
  assign bus.wb_we_o  = r_we;
  assign bus.wb_adr_o = r_adr;
  assign bus.wb_dat_o = {DBUS_WIDTH{1'b0}};

endmodule
`default_nettype wire
